button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Conditions the four raw active-low player buttons (p1l, p1r, p2l, p2r) before they reach the game logic.
- Performs 2-flop synchronisation, per-button debounce, one-cycle press/release pulses and an auto-repeat "move" pulse stream for paddle motion.
- Acts as the producer side of the button interface that board_controller, ball_next_state and process_next_state consume.
- Outputs are active-high and synchronous to clk.

Parameters:
N_BTN, 4, number of button channels (bit 0=p1l, 1=p1r, 2=p2l, 3=p2r)
DEBOUNCE_CYCLES, 500000, cycles the synchronised input must hold a new value before it is accepted (10 ms at 50 MHz)
REPEAT_DELAY, 15000000, cycles from accepted press to first repeat pulse (300 ms)
REPEAT_PERIOD, 2500000, cycles between subsequent repeat pulses (50 ms)
CNT_W, 24, counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_n  input  N_BTN  raw buttons, active-low, asynchronous to clk
enable  input  1  1 = pulses allowed; 0 = press/repeat/release pulses suppressed, level still tracks
level  output  N_BTN  debounced button state, 1 = held
press  output  N_BTN  one-cycle pulse on accepted press
release  output  N_BTN  one-cycle pulse on accepted release
move  output  N_BTN  one-cycle pulse: on press, then auto-repeat while held

Behaviour:
- Reset (async, active-high): sync flops = 1 (released), all counters = 0, every channel FSM = IDLE; level, press, release, move = 0. Reset asserted mid-debounce or mid-repeat aborts immediately with no pulse.
- Sync: btn_n passes through 2 flops per bit; s = ~sync2 (active-high). Raw-to-s latency is 2 cycles.
- Per-channel FSM, states:
  - IDLE: level=0. If s=1, go to DB_PRESS and set cnt=0.
  - DB_PRESS: If s=0, return to IDLE (bounce rejected). Otherwise cnt++. When cnt==DEBOUNCE_CYCLES-1, go to HELD, set level=1, press=1 and move=1 for 1 cycle, cnt=0.
  - HELD: If s=0, go to DB_REL with cnt=0. Otherwise cnt++. When cnt==REPEAT_DELAY-1, go to REPEAT, move=1, cnt=0.
  - REPEAT: If s=0, go to DB_REL with cnt=0. Otherwise cnt++. When cnt==REPEAT_PERIOD-1, move=1 and cnt=0.
  - DB_REL: level stays 1. If s=1, return to the state held before (HELD or REPEAT) with cnt=0; repeat timing restarts. Otherwise cnt++. When cnt==DEBOUNCE_CYCLES-1, go to IDLE, level=0, release=1.
- Latency: a clean press asserts press/move exactly 2+DEBOUNCE_CYCLES cycles after the btn_n falling edge. Release latency is the same.
- All outputs are registered. Pulses are exactly one cycle wide, and press and move of the same channel coincide on the press cycle.
- Channels are fully independent. Simultaneous presses on several channels give simultaneous pulses; there is no priority or arbitration.
- enable=0:
  - FSM and level run normally.
  - press, release and move are forced to 0. Pulses due in that cycle are dropped, not queued.
  - Re-asserting enable while a button is held does not generate a press; the next move comes from the repeat timer.
- Counter never wraps: it is cleared on every state change. CNT_W too small is an elaboration-time error (assertion).
- Parameter value 1 is legal for every count: the transition happens on the first qualifying cycle.

Decomposition:
- Shared package ping_pong_pkg:
  - button index constants BTN_P1L=0, BTN_P1R=1, BTN_P2L=2, BTN_P2R=3
  - channel state encoding (IDLE, DB_PRESS, HELD, REPEAT, DB_REL, 3 bits)
  - default timing constants
- One sub-module, button_channel: single-bit sync + FSM + counter, with the same parameters. button_conditioner instantiates N_BTN copies in a generate loop and gates the pulses with enable.

Test Plan (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Clean press: btn_n[0] goes 1->0 at cycle 0 and held -> press[0], move[0] at cycle 6; level[0]=1 from cycle 6; move[0] again at cycles 16, 19, 22.
- Bounce: btn_n[1] low 3 cycles, high 1, low 2, then high -> no press/move/level on channel 1.
- Release: hold btn_n[2] low 20 cycles then high -> release[2] exactly 6 cycles after the rising edge; level[2] drops the same cycle; no further move.
- Simultaneous: btn_n=4'b0000 at cycle 0 -> press=4'b1111 at cycle 6, identical repeat pattern on all bits.
- Enable gating: enable=0 during press of channel 3 -> level[3]=1 at cycle 6, press[3]=0; enable=1 at cycle 8 -> first move[3] at cycle 16.
- Reset mid-operation: assert reset at cycle 12 while channel 0 is held -> all outputs 0 within the same cycle (asynchronous); after deassert with button still low, a new press pulse appears 2+4 cycles later.

Source files
------------

// File: rtl/ping_pong_pkg.sv
// Shared definitions for the ping-pong button path: button indices,
// channel FSM encoding and default timing constants (50 MHz clock).
package ping_pong_pkg;

   localparam int BTN_P1L = 0;
   localparam int BTN_P1R = 1;
   localparam int BTN_P2L = 2;
   localparam int BTN_P2R = 3;

   localparam int DEF_N_BTN           = 4;
   localparam int DEF_DEBOUNCE_CYCLES = 500000;
   localparam int DEF_REPEAT_DELAY    = 15000000;
   localparam int DEF_REPEAT_PERIOD   = 2500000;
   localparam int DEF_CNT_W           = 24;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DB_PRESS = 3'd1,
      HELD     = 3'd2,
      REPEAT   = 3'd3,
      DB_REL   = 3'd4
   } chan_state_e;

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, debounce/auto-repeat FSM and counter.
// Pulses are registered and qualified by en_i; level always tracks.
module button_channel
   import ping_pong_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        btn_n_i,
   input  logic        en_i,
   output logic        level_o,
   output logic        press_o,
   output logic        release_o,
   output logic        move_o,
   output chan_state_e state_o
);

   localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_count
      $error("button_channel: every count parameter must be at least 1");
   end
   if (longint'(DEBOUNCE_CYCLES) > CNT_MAX || longint'(REPEAT_DELAY) > CNT_MAX ||
       longint'(REPEAT_PERIOD) > CNT_MAX) begin : g_bad_cnt_w
      $error("button_channel: CNT_W too small for the configured counts");
   end

   // The IDLE cycle that first sees the press counts as debounce cycle one,
   // so the debounce states terminate one count earlier than the repeat states.
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
   localparam bit               DB_ONE  = (DEBOUNCE_CYCLES == 1);

   logic             sync1_q, sync2_q;
   logic             s;
   chan_state_e      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             rep_q;
   logic             level_q, press_q, release_q, move_q;

   assign s = ~sync2_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         state_q   <= IDLE;
         cnt_q     <= '0;
         rep_q     <= 1'b0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         move_q    <= 1'b0;
      end else begin
         sync1_q   <= btn_n_i;
         sync2_q   <= sync1_q;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         move_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (s) begin
                  cnt_q <= '0;
                  if (DB_ONE) begin
                     state_q <= HELD;
                     rep_q   <= 1'b0;
                     level_q <= 1'b1;
                     press_q <= en_i;
                     move_q  <= en_i;
                  end else begin
                     state_q <= DB_PRESS;
                  end
               end
            end
            DB_PRESS: begin
               if (!s) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == DB_LAST) begin
                  state_q <= HELD;
                  cnt_q   <= '0;
                  rep_q   <= 1'b0;
                  level_q <= 1'b1;
                  press_q <= en_i;
                  move_q  <= en_i;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            HELD, REPEAT: begin
               if (!s) begin
                  cnt_q <= '0;
                  if (DB_ONE) begin
                     state_q   <= IDLE;
                     level_q   <= 1'b0;
                     release_q <= en_i;
                  end else begin
                     state_q <= DB_REL;
                     rep_q   <= (state_q == REPEAT);
                  end
               end else if (cnt_q == ((state_q == HELD) ? RD_LAST : RP_LAST)) begin
                  state_q <= REPEAT;
                  cnt_q   <= '0;
                  move_q  <= en_i;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DB_REL: begin
               if (s) begin
                  // Release bounce: resume where we were, repeat timing restarts.
                  state_q <= rep_q ? REPEAT : HELD;
                  cnt_q   <= '0;
               end else if (cnt_q == DB_LAST) begin
                  state_q   <= IDLE;
                  cnt_q     <= '0;
                  level_q   <= 1'b0;
                  release_q <= en_i;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               level_q <= 1'b0;
            end
         endcase
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign move_o    = move_q;
   assign state_o   = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw active-low player buttons into debounced levels and
// press/release/move pulses; enable suppresses pulses without stopping the FSMs.
module button_conditioner
   import ping_pong_pkg::*;
#(
   parameter int N_BTN           = DEF_N_BTN,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [N_BTN-1:0]   btn_n_i,
   input  logic               enable_i,
   output logic [N_BTN-1:0]   level_o,
   output logic [N_BTN-1:0]   press_o,
   output logic [N_BTN-1:0]   release_o,
   output logic [N_BTN-1:0]   move_o,
   output logic [3*N_BTN-1:0] state_o
);

   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      chan_state_e ch_state;

      button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
         .CNT_W           (CNT_W)
      ) u_chan (
         .clk_i     (clk_i),
         .reset_i   (reset_i),
         .btn_n_i   (btn_n_i[i]),
         .en_i      (enable_i),
         .level_o   (level_o[i]),
         .press_o   (press_o[i]),
         .release_o (release_o[i]),
         .move_o    (move_o[i]),
         .state_o   (ch_state)
      );

      assign state_o[3*i +: 3] = ch_state;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing constants
// (debounce 4, repeat delay 10, repeat period 3).
module tb_button_conditioner;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  btn_n;
   logic        enable;
   logic [3:0]  level, press, rel, move;
   logic [11:0] state;

   int checks = 0;
   int errors = 0;
   int t = 0;

   always #5 clk = ~clk;

   button_conditioner #(
      .N_BTN           (4),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (3),
      .CNT_W           (8)
   ) dut (
      .clk_i     (clk),
      .reset_i   (reset),
      .btn_n_i   (btn_n),
      .enable_i  (enable),
      .level_o   (level),
      .press_o   (press),
      .release_o (rel),
      .move_o    (move),
      .state_o   (state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      t = t + 1;
   endtask

   task automatic goto(input int k);
      while (t < k) tick();
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s @cycle %0d: observed %b expected %b", tag, t, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_level"}, level, 4'b0000);
      chk({tag, "_press"}, press, 4'b0000);
      chk({tag, "_release"}, rel, 4'b0000);
      chk({tag, "_move"}, move, 4'b0000);
   endtask

   task automatic apply_reset();
      reset  = 1'b1;
      btn_n  = 4'b1111;
      enable = 1'b1;
      tick(); tick(); tick();
      chk_all_zero("in_reset");
      checks++;
      assert (state === 12'h000) else begin
         errors++;
         $error("FAIL reset_state: observed %h expected %h", state, 12'h000);
      end
      reset = 1'b0;
      tick(); tick();
      chk_all_zero("post_reset");
   endtask

   // Hold the buttons in mask from cycle 0; release at cycle hold (0 = keep held);
   // enable is low until cycle en_at when en_at >= 0.
   task automatic run_hold(input string tag, input logic [3:0] mask, input int hold,
                           input int en_at, input int n);
      bit lvl, prs, mov, rls, on;
      t      = 0;
      btn_n  = ~mask;
      enable = (en_at < 0);
      for (int k = 1; k <= n; k++) begin
         goto(k);
         on  = (hold == 0) || (k <= hold + 2);
         lvl = (k >= 6) && ((hold == 0) || (k < hold + 6));
         prs = (k == 6) && (k > en_at);
         mov = on && (k > en_at) && ((k == 6) || ((k >= 16) && ((k - 16) % 3 == 0)));
         rls = (hold != 0) && (k == hold + 6) && (k > en_at);
         chk({tag, "_level"},   level, lvl ? mask : 4'b0000);
         chk({tag, "_press"},   press, prs ? mask : 4'b0000);
         chk({tag, "_move"},    move,  mov ? mask : 4'b0000);
         chk({tag, "_release"}, rel,   rls ? mask : 4'b0000);
         if (k == hold) btn_n = 4'b1111;
         if (k == en_at) enable = 1'b1;
      end
   endtask

   initial begin
      reset  = 1'b1;
      btn_n  = 4'b1111;
      enable = 1'b1;

      apply_reset();
      run_hold("clean", 4'b0001, 0, -1, 25);

      apply_reset();
      t = 0;
      btn_n = 4'b1101;
      for (int k = 1; k <= 15; k++) begin
         goto(k);
         chk_all_zero("bounce");
         if (k == 3) btn_n = 4'b1111;
         if (k == 4) btn_n = 4'b1101;
         if (k == 6) btn_n = 4'b1111;
      end

      apply_reset();
      run_hold("release", 4'b0100, 20, -1, 32);

      apply_reset();
      run_hold("simul", 4'b1111, 0, -1, 25);

      apply_reset();
      run_hold("enable", 4'b1000, 0, 8, 25);

      apply_reset();
      t = 0;
      btn_n  = 4'b1110;
      enable = 1'b1;
      goto(12);
      chk("mid_level_before", level, 4'b0001);
      #2;
      reset = 1'b1;
      #1;
      chk_all_zero("async_reset");
      tick(); tick();
      chk_all_zero("held_reset");
      reset = 1'b0;
      t = 0;
      for (int k = 1; k <= 8; k++) begin
         goto(k);
         chk("rearm_press", press, (k == 6) ? 4'b0001 : 4'b0000);
         chk("rearm_move",  move,  (k == 6) ? 4'b0001 : 4'b0000);
         chk("rearm_level", level, (k >= 6) ? 4'b0001 : 4'b0000);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
